// File: rtl/alu_seq_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: sequencer states,
// slice width and the 181-style function codes used most often.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_nibble_sequencer.sv
// Runs one wide operation through an external 4-bit 181-style ALU slice,
// one nibble per clock (least-significant first), chaining the carry in a
// register and assembling f / cout / eqv into a single wide response.
import alu_seq_pkg::*;

module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    // request side
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  req_b,
    input  logic [3:0]                   req_s,
    input  logic                         req_m,
    input  logic                         req_cin,
    // ALU side
    output logic [NIBBLE_W-1:0]          alu_a,
    output logic [NIBBLE_W-1:0]          alu_b,
    output logic [3:0]                   alu_s,
    output logic                         alu_m,
    output logic                         alu_cin,
    input  logic [NIBBLE_W-1:0]          alu_f,
    input  logic                         alu_cout,
    input  logic                         alu_eqv,
    // response side
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  rsp_f,
    output logic                         rsp_cout,
    output logic                         rsp_eqv
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    seq_state_e        state_r;
    seq_state_e        state_s;
    logic              ready_r;
    logic              valid_r;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic [3:0]        s_r;
    logic              m_r;
    logic [IDX_W-1:0]  idx_r;
    logic              carry_r;
    logic              eqv_r;
    logic [W-1:0]      result_r;
    logic              accept_s;
    logic [NIBBLE_W-1:0] alu_a_s;
    logic [NIBBLE_W-1:0] alu_b_s;
    logic              alu_cin_s;

    // ready_r is only ever high in IDLE, so it doubles as the accept qualifier
    assign accept_s = (state_r == IDLE) && ready_r && req_valid;

    // Next-state logic: accept in IDLE, step through nibbles, hold in DONE
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus registered handshake flags derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            ready_r <= (state_s == IDLE);
            valid_r <= (state_s == DONE);
        end
    end

    // Operand capture, per-nibble result collection and carry/eqv chaining
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= 4'd0;
            m_r      <= 1'b0;
            idx_r    <= '0;
            carry_r  <= 1'b0;
            eqv_r    <= 1'b0;
            result_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r      <= req_a;
                        b_r      <= req_b;
                        s_r      <= req_s;
                        m_r      <= req_m;
                        idx_r    <= '0;
                        carry_r  <= req_cin;
                        eqv_r    <= 1'b1;
                        result_r <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_r == IDX_W'(i)) begin
                            result_r[i*NIBBLE_W +: NIBBLE_W] <= alu_f;
                        end
                    end
                    // carry is chained raw; in logic mode the ALU ignores it
                    carry_r <= alu_cout;
                    eqv_r   <= eqv_r & alu_eqv;
                    idx_r   <= idx_r + IDX_W'(1);
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    // Select the current operand nibbles for the ALU; quiet outside RUN
    always_comb begin
        alu_a_s   = '0;
        alu_b_s   = '0;
        alu_cin_s = 1'b0;
        if (state_r == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                alu_a_s = (idx_r == IDX_W'(i)) ? a_r[i*NIBBLE_W +: NIBBLE_W] : alu_a_s;
                alu_b_s = (idx_r == IDX_W'(i)) ? b_r[i*NIBBLE_W +: NIBBLE_W] : alu_b_s;
            end
            alu_cin_s = carry_r;
        end else begin
            alu_cin_s = 1'b0;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_f     = result_r;
    assign rsp_cout  = carry_r;
    assign rsp_eqv   = eqv_r;
    assign alu_a     = alu_a_s;
    assign alu_b     = alu_b_s;
    assign alu_s     = s_r;
    assign alu_m     = m_r;
    assign alu_cin   = alu_cin_s;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer (NIBBLES=4). A behavioural
// 181-style 4-bit ALU sits on the ALU-side ports; a wide-word reference model
// predicts every output each cycle; directed cases pin literal results.
import alu_seq_pkg::*;

module tb_alu_nibble_sequencer;

    localparam int N = 4;
    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  req_a;
    logic [W-1:0]  req_b;
    logic [3:0]    req_s;
    logic          req_m;
    logic          req_cin;
    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [3:0]    alu_s;
    logic          alu_m;
    logic          alu_cin;
    logic [3:0]    alu_f;
    logic          alu_cout;
    logic          alu_eqv;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_f;
    logic          rsp_cout;
    logic          rsp_eqv;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_m(req_m), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .alu_eqv(alu_eqv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_f(rsp_f), .rsp_cout(rsp_cout), .rsp_eqv(rsp_eqv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit 181-style slice, active-high data and carry
    logic [3:0] ax, ay;
    logic [4:0] asum;
    always_comb begin
        ax       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        ay       = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
        asum     = {1'b0, ax} + {1'b0, ay} + {4'd0, alu_cin};
        alu_f    = alu_m ? ~(ax ^ ay) : asum[3:0];
        alu_cout = asum[4];
        alu_eqv  = (alu_a == alu_b);
    end

    // ---------------- wide reference model ----------------
    function automatic logic [W-1:0] gen_x(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
        return a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    endfunction

    function automatic logic [W-1:0] gen_y(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s);
        return (a & b & {W{s[3]}}) | (a & ~b & {W{s[2]}});
    endfunction

    // carry entering bit position 4*k of the whole-word sum
    function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [3:0] s, input logic cin, input int k);
        logic [W:0] mask;
        logic [W:0] sum;
        mask = '0;
        for (int j = 0; j < 4 * k; j++) mask[j] = 1'b1;
        sum = ({1'b0, gen_x(a, b, s)} & mask) + ({1'b0, gen_y(a, b, s)} & mask) + {{W{1'b0}}, cin};
        return sum[4 * k];
    endfunction

    int            run_left = 0;
    logic          m_ready = 1'b0;
    logic          m_valid = 1'b0;
    logic [W-1:0]  m_f = '0;
    logic          m_cout = 1'b0;
    logic          m_eqv = 1'b0;
    logic [W-1:0]  o_a = '0;
    logic [W-1:0]  o_b = '0;
    logic [3:0]    o_s = 4'd0;
    logic          o_m = 1'b0;
    logic          o_cin = 1'b0;

    // model advance on each active edge
    always @(posedge clk) begin
        logic [W:0] sum;
        if (rst) begin
            run_left = 0; m_ready = 1'b0; m_valid = 1'b0;
            m_f = '0; m_cout = 1'b0; m_eqv = 1'b0;
            o_a = '0; o_b = '0; o_s = 4'd0; o_m = 1'b0; o_cin = 1'b0;
        end else if (m_valid) begin
            if (rsp_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end else if (run_left > 0) begin
            run_left = run_left - 1;
            if (run_left == 0) m_valid = 1'b1;
        end else if (m_ready && req_valid) begin
            o_a = req_a; o_b = req_b; o_s = req_s; o_m = req_m; o_cin = req_cin;
            sum = {1'b0, gen_x(o_a, o_b, o_s)} + {1'b0, gen_y(o_a, o_b, o_s)} + {{W{1'b0}}, o_cin};
            m_f    = o_m ? ~(gen_x(o_a, o_b, o_s) ^ gen_y(o_a, o_b, o_s)) : sum[W-1:0];
            m_cout = sum[W];
            m_eqv  = (o_a == o_b);
            run_left = N;
            m_ready = 1'b0;
        end else begin
            m_ready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        int k;
        if (cmp_en) begin
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("alu_s", 32'(alu_s), 32'(o_s));
            chk("alu_m", 32'(alu_m), 32'(o_m));
            if (run_left > 0) begin
                k = N - run_left;
                chk("alu_a", 32'(alu_a), 32'(o_a[4*k +: 4]));
                chk("alu_b", 32'(alu_b), 32'(o_b[4*k +: 4]));
                chk("alu_cin", 32'(alu_cin), 32'(carry_into(o_a, o_b, o_s, o_cin, k)));
            end else begin
                chk("alu_a_idle", 32'(alu_a), 32'd0);
                chk("alu_b_idle", 32'(alu_b), 32'd0);
                chk("alu_cin_idle", 32'(alu_cin), 32'd0);
                chk("rsp_f", 32'(rsp_f), 32'(m_f));
                chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
                chk("rsp_eqv", 32'(rsp_eqv), 32'(m_eqv));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic cin,
                          input logic [W-1:0] ef, input logic ec, input logic ee,
                          input int hold, output logic [3:0] cins);
        int guard;
        int lat;
        cins = 4'd0;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_s = s; req_m = m; req_cin = cin;
        req_valid = 1'b1; rsp_ready = 1'b0;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_accept_wait"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;                // accept edge T
        req_valid = 1'b0;
        cins[0] = alu_cin;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            lat = i;
            if (rsp_valid) break;
            if (i < N) cins[i] = alu_cin;
        end
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_f"}, 32'(rsp_f), 32'(ef));
        chk({name, "_cout"}, 32'(rsp_cout), 32'(ec));
        chk({name, "_eqv"}, 32'(rsp_eqv), 32'(ee));
        // optional backpressure with a competing request
        for (int i = 0; i < hold; i++) begin
            req_a = 16'h5A5A; req_b = 16'hA5A5; req_valid = 1'b1;
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({name, "_hold_f"}, 32'(rsp_f), 32'(ef));
            chk({name, "_hold_cout"}, 32'(rsp_cout), 32'(ec));
            chk({name, "_hold_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, "_drop_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [3:0] cins;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_s = 4'd0;
        req_m = 1'b0; req_cin = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        cmp_en = 1'b1;
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_valid", 32'(rsp_valid), 32'd0);
        chk("reset_f", 32'(rsp_f), 32'd0);
        chk("reset_alu_s", 32'(alu_s), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        run_op("add", 16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, cins);
        run_op("ripple", 16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, cins);
        chk("ripple_cin_n1", 32'(cins[1]), 32'd1);
        chk("ripple_cin_n2", 32'(cins[2]), 32'd1);
        chk("ripple_cin_n3", 32'(cins[3]), 32'd1);
        run_op("and", 16'hF0F0, 16'hFF00, S_AND, 1'b1, 1'b0, 16'hF000, 1'b1, 1'b0, 0, cins);
        run_op("eq", 16'h1234, 16'h1234, S_ADD, 1'b0, 1'b0, 16'h2468, 1'b0, 1'b1, 0, cins);
        run_op("neq", 16'h1234, 16'h1235, S_SUB, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 5, cins);
        // the competing request during backpressure must not have been taken
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("no_second_rsp", 32'(rsp_valid), 32'd0);
        end

        // reset while RUN is on nibble 2
        @(posedge clk); #1;
        req_a = 16'h1111; req_b = 16'h2222; req_s = S_ADD; req_m = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;                // accept edge
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;                // idx = 2 now
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready_low", 32'(req_ready), 32'd0);
        chk("abort_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_a", 32'(alu_a), 32'd0);
        @(posedge clk); #1;
        chk("abort_ready_back", 32'(req_ready), 32'd1);
        chk("abort_valid2", 32'(rsp_valid), 32'd0);
        run_op("post_abort", 16'h7FFF, 16'h0001, S_ADD, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 0, cins);

        // randomized traffic, backpressure and occasional resets
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
            req_a     = 16'($urandom);
            req_b     = ($urandom_range(0, 7) == 0) ? req_a : 16'($urandom);
            req_s     = 4'($urandom_range(0, 15));
            req_m     = 1'($urandom_range(0, 1));
            req_cin   = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
